// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes for the shared 32-bit ALU and the
// state encoding used by the shift-add multiplier sequencer.
package alu_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer that borrows the shared ALU for its
// accumulate additions whenever the CPU is not requesting it.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-low reset
//   start, op_a, op_b   request pulse (sampled in IDLE) and operands
//   busy, done, result  handshake and low WIDTH bits of op_a*op_b
//   cpu_alu_req         CPU needs the ALU this cycle (always wins)
//   alu_own             sequencer drives the ALU inputs this cycle
//   alu_a, alu_b        ALU operands (accumulator, shifted multiplicand)
//   alu_fun, alu_sign   ALU function code / sign control
//   alu_z               ALU result, combinational from alu_a/alu_b/alu_fun
//
// Build option: MULSEQ_EARLY_EXIT_EN ends the run as soon as the remaining
// multiplier bits are all zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MS_IDLE | waiting for start; operands captured on acceptance
// MS_RUN  | one shift-add iteration per non-stalled cycle
// MS_DONE | result valid, done pulse, back to idle next cycle
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    input  logic             cpu_alu_req,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_fun,
    output logic             alu_sign,
    input  logic [WIDTH-1:0] alu_z
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    ms_state_t        state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] mplr, mplr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             exit_now;
    logic             load_result;

`ifdef MULSEQ_EARLY_EXIT_EN
    assign exit_now = (mplr == '0);
`else
    assign exit_now = 1'b0;
`endif

    // The CPU always has priority; the sequencer only takes the ALU when
    // the current multiplier bit actually needs an addition.
    assign alu_own  = (state == MS_RUN) & mplr[0] & ~cpu_alu_req;
    assign alu_a    = alu_own ? acc   : '0;
    assign alu_b    = alu_own ? mcand : '0;
    assign alu_fun  = alu_own ? ALU_ADD : 6'b000000;
    assign alu_sign = 1'b0;

    assign busy = (state != MS_IDLE);
    assign done = (state == MS_DONE);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mcand_nxt = mcand;
        mplr_nxt  = mplr;
        cnt_nxt   = cnt;
        case (state)
            MS_IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    mcand_nxt = op_a;
                    mplr_nxt  = op_b;
                    cnt_nxt   = '0;
                    state_nxt = MS_RUN;
                end
            end
            MS_RUN: begin
                if (exit_now) begin
                    state_nxt = MS_DONE;
                end else if (!(mplr[0] && cpu_alu_req)) begin
                    if (mplr[0]) begin
                        acc_nxt = alu_z;
                    end
                    mcand_nxt = mcand << 1;
                    mplr_nxt  = mplr >> 1;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state_nxt = MS_DONE;
                    end
                end
            end
            MS_DONE: begin
                state_nxt = MS_IDLE;
            end
            default: begin
                state_nxt = MS_IDLE;
            end
        endcase
    end

    // Result is captured on the edge into DONE (including the final
    // accumulate) so it is already valid while done is high.
    assign load_result = (state == MS_RUN) && (state_nxt == MS_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= MS_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            mcand <= mcand_nxt;
            mplr  <= mplr_nxt;
            cnt   <= cnt_nxt;
            if (load_result) begin
                result <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int MAXC  = 256;
`ifdef MULSEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             cpu_alu_req = 1'b0;
    logic             alu_own;
    logic [WIDTH-1:0] alu_a, alu_b, alu_z;
    logic [5:0]       alu_fun;
    logic             alu_sign;

    int checks = 0;
    int errors = 0;
    bit req_arr [0:MAXC-1];

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign alu_z = (alu_fun == ALU_ADD) ? alu_a + alu_b : alu_a - alu_b;

    alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .cpu_alu_req(cpu_alu_req), .alu_own(alu_own), .alu_a(alu_a),
        .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign), .alu_z(alu_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle (relative to the acceptance cycle) in which done is expected.
    // Walk the multiplier bits in order; a set bit cannot be processed in a
    // cycle where the CPU holds the ALU.
    function automatic int model_done(input logic [31:0] b);
        int i = 0;
        int c = 1;
        while (c < MAXC - 4) begin
            if (i == WIDTH) return c;
            if (EARLY && ((b >> i) == 0)) return c + 1;
            if (!(b[i] && req_arr[c])) i++;
            c++;
        end
        return c;
    endfunction

    task automatic fill_req(input int mode);
        for (int k = 0; k < MAXC; k++) begin
            case (mode)
                0: req_arr[k] = 1'b0;
                1: req_arr[k] = ($urandom_range(0, 2) == 0);
                default: req_arr[k] = 1'b0;
            endcase
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        int exp_done, obs_done, ndone, nbusy, nown, bad_own, bad_idle;
        logic [31:0] prod;
        prod = a * b;
        exp_done = model_done(b);
        obs_done = -1; ndone = 0; nbusy = 0; nown = 0; bad_own = 0; bad_idle = 0;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cpu_alu_req = 1'b0;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            cpu_alu_req = req_arr[c];
            if (noise) begin
                start = (c == exp_done) ? 1'b1 : ($urandom_range(0, 3) == 0);
                op_a = $urandom; op_b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (c == exp_done + 1) start = 1'b0;
            #1;
            if (done) begin
                ndone++;
                if (obs_done < 0) begin
                    obs_done = c;
                    chk({tag, " result@done"}, result, prod);
                end
            end
            if (busy && c <= exp_done) nbusy++;
            if (alu_own) nown++;
            if (alu_own && cpu_alu_req) bad_own++;
            if (!alu_own && (alu_a != 0 || alu_b != 0 || alu_fun != 0)) bad_idle++;
            if (alu_sign !== 1'b0) bad_idle++;
        end
        chk({tag, " done_cycle"}, obs_done, exp_done);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " busy_cycles"}, nbusy, exp_done);
        chk({tag, " busy_after"}, {31'b0, busy}, 0);
        chk({tag, " result_held"}, result, prod);
        chk({tag, " own_cycles"}, nown, $countones(b));
        chk({tag, " own_vs_cpu"}, bad_own, 0);
        chk({tag, " mux_quiet"}, bad_idle, 0);
        start = 1'b0; cpu_alu_req = 1'b0;
    endtask

    initial begin
        int ndone;
        // reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst done", {31'b0, done}, 0);
        chk("rst result", result, 0);
        chk("rst own", {31'b0, alu_own}, 0);
        @(negedge clk);
        reset = 1'b1;

        fill_req(0);
        run_op("3x5", 32'd3, 32'd5, 1'b0);
        run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        fill_req(0);
        for (int k = 1; k <= 4; k++) req_arr[k] = 1'b1;
        run_op("7x15stall", 32'd7, 32'h0000_000F, 1'b0);

        fill_req(0);
        req_arr[1] = 1'b1;
        run_op("6x2nostall", 32'd6, 32'd2, 1'b0);

        fill_req(0);
        run_op("6x1", 32'd6, 32'd1, 1'b1);
        run_op("5x0", 32'd5, 32'd0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (n % 3 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            fill_req(1);
            run_op($sformatf("rnd%0d", n), ra, rb, 1'b1);
        end

        // reset in the middle of a 9*9 run
        fill_req(0);
        @(negedge clk);
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst busy", {31'b0, busy}, 0);
        chk("midrst done", {31'b0, done}, 0);
        chk("midrst result", result, 0);
        chk("midrst own", {31'b0, alu_own}, 0);
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        run_op("4x4", 32'd4, 32'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
